// File: rtl/cpu_timer_master.sv
// Avalon-MM master that programs and services a 16-bit interval-timer slave:
// loads the period, starts continuous mode, acknowledges each IRQ, reads
// counter snapshots on request and stops the timer on request.
module cpu_timer_master #(
    parameter logic [31:0] PERIOD       = 32'd999999,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_req,
    input  logic        stop_req,
    input  logic        snap_req,
    input  logic        irq,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        running,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snapshot_valid
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, SNAP_CAP, SNAP_RL, SNAP_RH, WR_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        cs_q, cs_d, wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d, snap_lo_q, snap_lo_d;
    logic        running_q, running_d, tick_q, tick_d, snap_vld_q, snap_vld_d;
    logic [31:0] tick_count_q, tick_count_d, snapshot_q, snapshot_d;
    logic        stop_pend_q, stop_pend_d, snap_pend_q, snap_pend_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  lat_q, lat_d;

    logic [2:0]  bus_addr;
    logic [15:0] bus_data;
    logic        bus_rd;
    logic        step;
    logic        run_family;

    // Transaction issued by each bus state
    always_comb begin
        bus_addr = 3'd0;
        bus_data = 16'h0000;
        bus_rd   = 1'b0;
        case (state_q)
            WR_PL:    begin bus_addr = 3'd2; bus_data = PERIOD[15:0];  end
            WR_PH:    begin bus_addr = 3'd3; bus_data = PERIOD[31:16]; end
            WR_CTL:   begin bus_addr = 3'd1; bus_data = 16'h0007;      end
            CLR_ST:   bus_addr = 3'd0;
            SNAP_CAP: bus_addr = 3'd4;
            SNAP_RL:  begin bus_addr = 3'd4; bus_rd = 1'b1; end
            SNAP_RH:  begin bus_addr = 3'd5; bus_rd = 1'b1; end
            WR_STOP:  begin bus_addr = 3'd1; bus_data = 16'h0008;      end
            default:  ;
        endcase
    end

    // Next-state, bus handshake and sequence side effects
    always_comb begin
        state_d      = state_q;
        cs_d         = cs_q;
        wn_d         = wn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        snap_lo_d    = snap_lo_q;
        running_d    = running_q;
        tick_d       = 1'b0;
        snap_vld_d   = 1'b0;
        tick_count_d = tick_count_q;
        snapshot_d   = snapshot_q;
        stop_pend_d  = stop_pend_q;
        snap_pend_d  = snap_pend_q;
        rd_pend_d    = rd_pend_q;
        lat_d        = lat_q;
        step         = 1'b0;

        // Requests are only latched while the timer is running (not while stopping)
        run_family = (state_q == RUN) || (state_q == CLR_ST) || (state_q == SNAP_CAP) ||
                     (state_q == SNAP_RL) || (state_q == SNAP_RH);
        if (stop_req && run_family) stop_pend_d = 1'b1;
        if (snap_req && run_family) snap_pend_d = 1'b1;

        case (state_q)
            IDLE: if (start_req) state_d = WR_PL;
            RUN: begin
                if (irq) begin
                    state_d = CLR_ST;
                end else if (stop_pend_q) begin
                    state_d     = WR_STOP;
                    stop_pend_d = 1'b0;
                end else if (snap_pend_q) begin
                    state_d     = SNAP_CAP;
                    snap_pend_d = 1'b0;
                end
            end
            default: begin
                if (cs_q) begin
                    // Hold address/data until the slave accepts; dropping cs on
                    // completion guarantees the idle cycle between transactions.
                    if (!m_waitrequest) begin
                        cs_d = 1'b0;
                        wn_d = 1'b1;
                        if (bus_rd) begin
                            rd_pend_d = 1'b1;
                            lat_d     = 2'(READ_LATENCY - 1);
                        end else begin
                            step = 1'b1;
                        end
                    end
                end else if (rd_pend_q) begin
                    if (lat_q == 2'd0) begin
                        rd_pend_d = 1'b0;
                        step      = 1'b1;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end else begin
                    cs_d    = 1'b1;
                    addr_d  = bus_addr;
                    wdata_d = bus_data;
                    wn_d    = bus_rd;
                end
            end
        endcase

        // Write completed or read data sampled: advance the sequence
        if (step) begin
            case (state_q)
                WR_PL:    state_d = WR_PH;
                WR_PH:    state_d = WR_CTL;
                WR_CTL: begin
                    state_d   = RUN;
                    running_d = 1'b1;
                end
                CLR_ST: begin
                    state_d      = RUN;
                    tick_d       = 1'b1;
                    tick_count_d = tick_count_q + 32'd1;
                end
                SNAP_CAP: state_d = SNAP_RL;
                SNAP_RL: begin
                    state_d   = SNAP_RH;
                    snap_lo_d = m_readdata;
                end
                SNAP_RH: begin
                    state_d    = RUN;
                    snapshot_d = {m_readdata, snap_lo_q};
                    snap_vld_d = 1'b1;
                end
                WR_STOP: begin
                    state_d     = IDLE;
                    running_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    snap_pend_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
            snap_lo_q    <= 16'h0000;
            running_q    <= 1'b0;
            tick_q       <= 1'b0;
            snap_vld_q   <= 1'b0;
            tick_count_q <= 32'd0;
            snapshot_q   <= 32'd0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            lat_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            snap_lo_q    <= snap_lo_d;
            running_q    <= running_d;
            tick_q       <= tick_d;
            snap_vld_q   <= snap_vld_d;
            tick_count_q <= tick_count_d;
            snapshot_q   <= snapshot_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            rd_pend_q    <= rd_pend_d;
            lat_q        <= lat_d;
        end
    end

    assign m_address      = addr_q;
    assign m_chipselect   = cs_q;
    assign m_write_n      = wn_q;
    assign m_writedata    = wdata_q;
    assign running        = running_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign snapshot       = snapshot_q;
    assign snapshot_valid = snap_vld_q;

endmodule
